// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_pkg -- shared types and register map for the bus UART transmitter
// Revision 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [7:0] TX_DATA_OFS = 8'd0;
  localparam logic [7:0] TX_STAT_OFS = 8'd1;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;

  // The status nibble holds at most 15; a 16-deep FIFO that is full reports 15.
  function automatic logic [3:0] sat_count(input logic [4:0] cnt);
    return (cnt > 5'd15) ? 4'hF : cnt[3:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_fifo -- synchronous FIFO with occupancy count for the UART transmitter
// Revision 1.0
// ----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int  DEPTH = 8,
  parameter int  WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      count_q;
  logic             pop_ok;
  logic             push_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];

  // A pop on the same edge frees the slot, so a push while full is still taken.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_bus_io.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_bus_io -- bus-mapped 8N1 UART transmitter with status and drain irq
// Revision 1.0
// ----------------------------------------------------------------------------
module uart_tx_bus_io
  import uart_pkg::*;
#(
  parameter int         CLK_FREQ   = 100000000,
  parameter int         BAUD       = 115200,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] BASE_ADDR  = 8'h90
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BUS_ADDR,
  inout  wire  [7:0] BUS_DATA,
  input  logic       BUS_WE,
  output logic       UART_TX,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  localparam int             DIV         = CLK_FREQ / BAUD;
  localparam int             CW          = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int             AW          = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0]  BAUD_RELOAD = CW'(DIV - 1);
  localparam logic [7:0]     ADDR_DATA   = BASE_ADDR + TX_DATA_OFS;
  localparam logic [7:0]     ADDR_STAT   = BASE_ADDR + TX_STAT_OFS;

  tx_state_t      state_q, state_d;
  logic [CW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           irq_q, irq_d;
  logic           irq_en_q;
  logic           ovf_q;
  logic           rd_en_q;
  logic [7:0]     rd_data_q;

  logic           wr_data, wr_stat, rd_data, rd_stat;
  logic           fifo_pop, fifo_full, fifo_empty;
  logic [7:0]     fifo_rdata;
  logic [AW:0]    fifo_count;
  logic           drop;
  logic           raise;
  logic           busy;
  logic [7:0]     status;

  assign wr_data = BUS_WE  && (BUS_ADDR == ADDR_DATA);
  assign wr_stat = BUS_WE  && (BUS_ADDR == ADDR_STAT);
  assign rd_data = !BUS_WE && (BUS_ADDR == ADDR_DATA);
  assign rd_stat = !BUS_WE && (BUS_ADDR == ADDR_STAT);
  assign drop    = wr_data && fifo_full && !fifo_pop;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RESET),
    .push_i  (wr_data),
    .pop_i   (fifo_pop),
    .data_i  (BUS_DATA),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign busy = !fifo_empty || (state_q != IDLE);

  always_comb begin
    status           = '0;
    status[7:4]      = sat_count(5'(fifo_count));
    status[ST_OVF]   = ovf_q;
    status[ST_EMPTY] = fifo_empty;
    status[ST_FULL]  = fifo_full;
    status[ST_BUSY]  = busy;
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    raise    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          state_d  = START;
          baud_d   = BAUD_RELOAD;
        end
      end
      START: begin
        if (baud_q == '0) begin
          state_d = DATA;
          bit_d   = 3'd0;
          baud_d  = BAUD_RELOAD;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      STOP: begin
        if (baud_q == '0) begin
          baud_d = BAUD_RELOAD;
          // Chain straight into the next start bit so queued bytes leave gap-free.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            state_d  = START;
          end else begin
            state_d = IDLE;
            raise   = irq_en_q;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase

    if (raise)                  irq_d = 1'b1;
    else if (BUS_INTERRUPT_ACK) irq_d = 1'b0;
    else                        irq_d = irq_q;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      baud_q    <= BAUD_RELOAD;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
      irq_q     <= 1'b0;
      irq_en_q  <= 1'b0;
      ovf_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      irq_q     <= irq_d;
      if (wr_stat) irq_en_q <= BUS_DATA[0];
      if (rd_stat)   ovf_q <= 1'b0;
      else if (drop) ovf_q <= 1'b1;
      rd_en_q   <= rd_stat || rd_data;
      rd_data_q <= rd_stat ? status : 8'h00;
    end
  end

  assign BUS_DATA            = rd_en_q ? rd_data_q : 8'hzz;
  assign UART_TX             = tx_q;
  assign BUS_INTERRUPT_RAISE = irq_q;

endmodule
`default_nettype wire

// File: doc/uart_tx_bus_io.md
Name: uart_tx_bus_io

Overview:
Memory-mapped UART transmitter on the 8-bit processor bus, alongside the LED, seven-segment, mouse and timer peripherals. The processor writes bytes into an internal FIFO. The block serialises them 8N1 onto UART_TX at a fixed baud rate. A status register is readable, and an optional interrupt fires when the transmitter drains.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD, 115200, line rate; DIV = CLK_FREQ/BAUD (integer truncation, 868 at defaults)
FIFO_DEPTH, 8, transmit FIFO entries; must be a power of 2, range 2..16
BASE_ADDR, 8'h90, bus base address; block occupies BASE_ADDR and BASE_ADDR+1

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-low reset
BUS_ADDR  in  8  bus address
BUS_DATA  inout  8  bus data; driven only during a read of this block, else high-Z
BUS_WE  in  1  bus write enable
UART_TX  out  1  serial output; idles high
BUS_INTERRUPT_RAISE  out  1  transmitter-drained interrupt request
BUS_INTERRUPT_ACK  in  1  interrupt acknowledge from the processor

Behaviour:
- Reset (RESET=0, asynchronous):
  - UART_TX=1, BUS_INTERRUPT_RAISE=0, BUS_DATA=Z.
  - FIFO emptied, state IDLE, overflow=0, irq_en=0.
  - Applies mid-frame: the line returns high at once and the byte in flight is lost.
- Write BASE+0 (BUS_WE=1): push BUS_DATA[7:0] into the FIFO on that edge.
  - If the FIFO is full, the byte is dropped and the sticky overflow bit is set.
  - Push and pop on the same edge while full: the pop is taken first and the push is accepted; count is unchanged.
- Write BASE+1: irq_en <= BUS_DATA[0]. Other bits are ignored.
- Read BASE+1 (BUS_WE=0):
  - Status is registered on the edge where the address matches and driven on BUS_DATA for the following cycle.
  - Layout: [7:4]=count (saturates at 15), [3]=overflow, [2]=empty, [1]=full, [0]=busy.
  - busy = FIFO non-empty OR state != IDLE.
  - Reading status clears overflow on the same edge; the value returned is the pre-clear value.
- Read BASE+0 returns 8'h00 with the same one-cycle timing. All other addresses: BUS_DATA=Z.
- Transmit FSM states: IDLE, START, DATA, STOP. Baud counter is ceil(log2(DIV)) bits and reloads on every state change.
  - IDLE: if the FIFO is non-empty, pop into the shift register and go to START. UART_TX goes low on the cycle after the pop.
  - START: UART_TX=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: UART_TX=shift[0] (LSB first) for DIV cycles per bit, shifting right after each bit. After bit 7, go to STOP.
  - STOP: UART_TX=1 for DIV cycles. On the last cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
  - Frame length is exactly 10*DIV cycles.
- Interrupt:
  - Raised on the edge the FSM enters IDLE from STOP with the FIFO empty and irq_en=1.
  - Held until BUS_INTERRUPT_ACK=1, which clears it on the next edge.
  - If ACK and a new raise condition occur on the same edge, the raise wins.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. count is log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Package uart_pkg:
  - tx_state_t enum (IDLE, START, DATA, STOP)
  - register offset constants (TX_DATA_OFS=0, TX_STAT_OFS=1)
  - status bit index constants (ST_BUSY, ST_FULL, ST_EMPTY, ST_OVF)
- One sub-module, uart_tx_fifo (parameterised synchronous FIFO with push, pop, full, empty and count). The bus decode, status register and FSM stay in the top module.

Test Plan:
- CLK_FREQ=16, BAUD=1 (DIV=16); write 8'h55 to 8'h90 -> UART_TX high until the pop edge, then 0 for 16 cycles, then 1,0,1,0,1,0,1,0 at 16 cycles each, then 1 for 16 cycles; busy reads 0 after cycle 160.
- Write 10 bytes back-to-back while the first is transmitting -> 9 accepted (1 in shifter + 8 in FIFO), 10th dropped; status reads 8'h8B (count=8, ovf, full, busy); a second read shows bit3=0.
- Write 8'hA3 then 8'h0F consecutively -> two frames with no gap between the stop bit of the first and the start bit of the second; total 320 cycles.
- Write 1 to 8'h91, then send one byte -> BUS_INTERRUPT_RAISE rises on the cycle STOP->IDLE; pulsing ACK clears it next edge; with irq_en=0 it never rises.
- Assert RESET=0 mid-DATA -> UART_TX=1 immediately (before the next edge), status reads 8'h04 after release, and no further frame starts.
- Read 8'h91 with idle FIFO -> BUS_DATA=8'h04 exactly one cycle after the address cycle; read 8'h92 -> BUS_DATA stays Z.
